// File: rtl/painterengine_gpu_reader_fifo_if.sv
// Stream bundle between the GPU reader channel, this FIFO and the compute unit.
// The slave view is the FIFO; the master view is the reader/consumer side.
interface painterengine_gpu_reader_fifo_if;
    logic [31:0] i_wire_data;
    logic        i_wire_data_valid;
    logic        o_wire_data_next;
    logic [31:0] o_wire_out_data;
    logic        o_wire_out_valid;
    logic        i_wire_out_ready;

    modport slave (
        input  i_wire_data,
        input  i_wire_data_valid,
        input  i_wire_out_ready,
        output o_wire_data_next,
        output o_wire_out_data,
        output o_wire_out_valid
    );

    modport master (
        output i_wire_data,
        output i_wire_data_valid,
        output i_wire_out_ready,
        input  o_wire_data_next,
        input  o_wire_out_data,
        input  o_wire_out_valid
    );
endinterface

// File: rtl/painterengine_gpu_reader_fifo.sv
// Elastic FWFT buffer behind one GPU DMA reader channel. Counts words in and
// out against a programmed length and reports done / error / timeout.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE  00 | after reset, waiting for start
// RUN   01 | accepting reader words and presenting them to the consumer
// DONE  10 | all length words consumed; holds until next start
// ERROR 11 | zero length or stall timeout; sticky until start or reset
module painterengine_gpu_reader_fifo #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_BIT = 18
) (
    input  logic                  i_wire_clock,
    input  logic                  i_wire_resetn,
    input  logic                  i_wire_start,
    input  logic [31:0]           i_wire_length,
    painterengine_gpu_reader_fifo_if.slave bus,
    output logic [ADDR_W:0]       o_wire_level,
    output logic                  o_wire_done,
    output logic                  o_wire_error,
    output logic [1:0]            o_wire_error_type
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DONE  = 2'b10,
        ST_ERROR = 2'b11
    } state_t;

    localparam logic [ADDR_W:0]      LVL_FULL  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]      LVL_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0]    PTR_ONE   = ADDR_W'(1);
    localparam logic [TIMEOUT_BIT:0] STALL_ONE = (TIMEOUT_BIT+1)'(1);

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]        level_q, level_d;
    logic [31:0]            in_count_q, in_count_d;
    logic [31:0]            out_count_q, out_count_d;
    logic [31:0]            length_q, length_d;
    logic [TIMEOUT_BIT:0]   stall_q, stall_d;
    logic [1:0]             etype_q, etype_d;

    logic [31:0]            mem [DEPTH];

    logic                   data_next;
    logic                   out_valid;
    logic                   push;
    logic                   pop;
    logic [TIMEOUT_BIT:0]   stall_inc;

    // Handshakes derive from registered state only, so RREADY has no input path.
    always_comb begin
        data_next = (state_q == ST_RUN) && (level_q != LVL_FULL) && (in_count_q != length_q);
        out_valid = (state_q == ST_RUN) && (level_q != '0);
        push      = bus.i_wire_data_valid && data_next;
        pop       = out_valid && bus.i_wire_out_ready;
        stall_inc = stall_q + STALL_ONE;
    end

    // Next-state computation for the FSM, pointers, counters and stall timer.
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        level_d     = level_q;
        in_count_d  = in_count_q;
        out_count_d = out_count_q;
        length_d    = length_q;
        stall_d     = stall_q;
        etype_d     = etype_q;
        case (state_q)
            ST_RUN: begin
                if (push) begin
                    wr_ptr_d   = wr_ptr_q + PTR_ONE;
                    in_count_d = in_count_q + 32'd1;
                end
                if (pop) begin
                    rd_ptr_d    = rd_ptr_q + PTR_ONE;
                    out_count_d = out_count_q + 32'd1;
                end
                case ({push, pop})
                    2'b10:   level_d = level_q + LVL_ONE;
                    2'b01:   level_d = level_q - LVL_ONE;
                    default: level_d = level_q;
                endcase
                stall_d = (push || pop) ? '0 : stall_inc;
                // A completing pop always wins; timeout can only fire on an idle cycle.
                if (pop && (out_count_d == length_q)) begin
                    state_d = ST_DONE;
                end else if (!push && !pop && stall_inc[TIMEOUT_BIT]) begin
                    state_d = ST_ERROR;
                    etype_d = 2'b10;
                end
            end
            default: begin
                if (i_wire_start) begin
                    length_d    = i_wire_length;
                    rd_ptr_d    = '0;
                    wr_ptr_d    = '0;
                    level_d     = '0;
                    in_count_d  = '0;
                    out_count_d = '0;
                    stall_d     = '0;
                    if (i_wire_length == 32'd0) begin
                        state_d = ST_ERROR;
                        etype_d = 2'b01;
                    end else begin
                        state_d = ST_RUN;
                        etype_d = 2'b00;
                    end
                end
            end
        endcase
    end

    // Control registers with asynchronous active-low reset.
    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state_q     <= ST_IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            in_count_q  <= '0;
            out_count_q <= '0;
            length_q    <= '0;
            stall_q     <= '0;
            etype_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            in_count_q  <= in_count_d;
            out_count_q <= out_count_d;
            length_q    <= length_d;
            stall_q     <= stall_d;
            etype_q     <= etype_d;
        end
    end

    // Storage array; contents intentionally survive reset.
    always_ff @(posedge i_wire_clock) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.i_wire_data;
        end
    end

    assign bus.o_wire_data_next = data_next;
    assign bus.o_wire_out_valid = out_valid;
    assign bus.o_wire_out_data  = (level_q != '0) ? mem[rd_ptr_q] : 32'd0;
    assign o_wire_level         = level_q;
    assign o_wire_done          = (state_q == ST_DONE);
    assign o_wire_error         = (state_q == ST_ERROR);
    assign o_wire_error_type    = etype_q;

endmodule

// File: tb/tb_painterengine_gpu_reader_fifo.sv
// Scenario bench for the reader FIFO: reset, streaming, backpressure,
// zero-length error, stall timeout and random wrap-around traffic.
module tb_painterengine_gpu_reader_fifo;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int TB_BIT = 10;

    logic              clk    = 1'b0;
    logic              rstn   = 1'b1;
    logic              start  = 1'b0;
    logic [31:0]       length = 32'd0;
    logic [ADDR_W:0]   level;
    logic              done;
    logic              error;
    logic [1:0]        etype;

    painterengine_gpu_reader_fifo_if bus ();

    painterengine_gpu_reader_fifo #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT_BIT(TB_BIT)
    ) u_dut (
        .i_wire_clock      (clk),
        .i_wire_resetn     (rstn),
        .i_wire_start      (start),
        .i_wire_length     (length),
        .bus               (bus),
        .o_wire_level      (level),
        .o_wire_done       (done),
        .o_wire_error      (error),
        .o_wire_error_type (etype)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] sb[$];
    int          cq[$];

    // Drive one cycle of stimulus at the falling edge and report which
    // handshakes will fire at the next rising edge. Accepted words go to the
    // scoreboard together with the cycle they were accepted in.
    task automatic step(input logic v, input logic r,
                        output logic pu, output logic po, output logic [31:0] od);
        @(negedge clk);
        cyc++;
        start = 1'b0;
        bus.i_wire_data_valid = v;
        bus.i_wire_data       = wdata;
        bus.i_wire_out_ready  = r;
        #1;
        pu = v && bus.o_wire_data_next;
        po = bus.o_wire_out_valid && r;
        od = bus.o_wire_out_data;
        if (pu) begin
            sb.push_back(wdata);
            cq.push_back(cyc);
            wdata = wdata + 32'd1;
        end
    endtask

    task automatic pulse_start(input logic [31:0] len);
        @(negedge clk);
        cyc++;
        start  = 1'b1;
        length = len;
        bus.i_wire_data_valid = 1'b0;
        bus.i_wire_out_ready  = 1'b0;
    endtask

    task automatic test_reset();
        logic pu, po;
        logic [31:0] od;
        int npush = 0;
        #2 rstn = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (level !== 0 || done !== 0 || error !== 0 || etype !== 0 ||
            bus.o_wire_data_next !== 0 || bus.o_wire_out_valid !== 0 || bus.o_wire_out_data !== 0) begin
            fails++;
            $display("FAIL reset_init: level=%0d done=%b error=%b type=%b next=%b ovalid=%b odata=%h, required all zero",
                     level, done, error, etype, bus.o_wire_data_next, bus.o_wire_out_valid, bus.o_wire_out_data);
        end
        @(negedge clk) rstn = 1'b1;
        pulse_start(32'd40);
        wdata = 32'h50;
        for (int i = 0; i < 12 && npush < 5; i++) begin
            step(1'b1, 1'b0, pu, po, od);
            if (pu) npush++;
        end
        step(1'b0, 1'b0, pu, po, od);
        tests++;
        if (level !== 5) begin
            fails++;
            $display("FAIL reset_pre_level: level=%0d required 5", level);
        end
        @(negedge clk) rstn = 1'b0;
        #1;
        tests++;
        if (level !== 0 || done !== 0 || error !== 0 ||
            bus.o_wire_data_next !== 0 || bus.o_wire_out_valid !== 0 || bus.o_wire_out_data !== 0) begin
            fails++;
            $display("FAIL reset_mid_run: level=%0d done=%b error=%b next=%b ovalid=%b odata=%h, required all zero",
                     level, done, error, bus.o_wire_data_next, bus.o_wire_out_valid, bus.o_wire_out_data);
        end
        @(negedge clk);
        @(negedge clk) rstn = 1'b1;
        #1;
        tests++;
        if (level !== 0 || done !== 0 || error !== 0 || bus.o_wire_data_next !== 0) begin
            fails++;
            $display("FAIL reset_after_release: level=%0d done=%b error=%b next=%b, required idle zeros",
                     level, done, error, bus.o_wire_data_next);
        end
        sb.delete();
        cq.delete();
    endtask

    task automatic test_basic_stream();
        logic pu, po;
        logic [31:0] od, exp;
        int pc;
        int npush = 0, npop = 0;
        logic done_seen = 1'b0;
        pulse_start(32'd8);
        wdata = 32'h100;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b1, pu, po, od);
            if (npop == 8 && !done_seen) begin
                done_seen = 1'b1;
                tests++;
                if (done !== 1'b1) begin
                    fails++;
                    $display("FAIL basic_done_timing: done=%b required 1 one cycle after last pop", done);
                end
            end
            if (pu) npush++;
            if (po) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL basic_extra_word: got %h with nothing outstanding", od);
                end else begin
                    exp = sb.pop_front();
                    pc  = cq.pop_front();
                    if (od !== exp || cyc !== pc + 1) begin
                        fails++;
                        $display("FAIL basic_data: got %h at cycle %0d, required %h at cycle %0d", od, cyc, exp, pc + 1);
                    end
                end
                npop++;
            end
        end
        tests++;
        if (npush !== 8 || npop !== 8 || !done_seen) begin
            fails++;
            $display("FAIL basic_counts: pushes=%0d pops=%0d done_seen=%b, required 8 8 1", npush, npop, done_seen);
        end
        tests++;
        if (done !== 1 || bus.o_wire_data_next !== 0 || bus.o_wire_out_valid !== 0) begin
            fails++;
            $display("FAIL basic_done_hold: done=%b next=%b ovalid=%b, required 1 0 0",
                     done, bus.o_wire_data_next, bus.o_wire_out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic pu, po;
        logic [31:0] od, exp;
        int npush = 0, npop = 0;
        pulse_start(32'd40);
        wdata = 32'h200;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, pu, po, od);
            if (pu) npush++;
        end
        step(1'b1, 1'b0, pu, po, od);
        if (pu) npush++;
        tests++;
        if (level !== 16 || bus.o_wire_data_next !== 0 || npush !== 16) begin
            fails++;
            $display("FAIL bp_full: level=%0d next=%b pushes=%0d, required 16 0 16", level, bus.o_wire_data_next, npush);
        end
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b1, pu, po, od);
            if (done) break;
            if (npush < 40) begin
                tests++;
                if (level !== 15 && level !== 16) begin
                    fails++;
                    $display("FAIL bp_level: level=%0d required 15 or 16", level);
                end
            end
            if (pu) npush++;
            if (po) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL bp_extra_word: got %h with nothing outstanding", od);
                end else begin
                    exp = sb.pop_front();
                    void'(cq.pop_front());
                    if (od !== exp) begin
                        fails++;
                        $display("FAIL bp_data: got %h required %h", od, exp);
                    end
                end
                npop++;
            end
        end
        tests++;
        if (npush !== 40 || npop !== 40 || done !== 1 || sb.size() != 0) begin
            fails++;
            $display("FAIL bp_counts: pushes=%0d pops=%0d done=%b left=%0d, required 40 40 1 0",
                     npush, npop, done, sb.size());
        end
    endtask

    task automatic test_zero_length();
        logic pu, po;
        logic [31:0] od, exp;
        int npop = 0;
        pulse_start(32'd0);
        step(1'b1, 1'b1, pu, po, od);
        tests++;
        if (error !== 1 || etype !== 2'b01 || done !== 0 || pu !== 0) begin
            fails++;
            $display("FAIL zero_len_error: error=%b type=%b done=%b push=%b, required 1 01 0 0", error, etype, done, pu);
        end
        pulse_start(32'd4);
        wdata = 32'h300;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b1, pu, po, od);
            if (i == 0) begin
                tests++;
                if (error !== 0 || etype !== 2'b00) begin
                    fails++;
                    $display("FAIL zero_len_clear: error=%b type=%b, required 0 00", error, etype);
                end
            end
            if (done) break;
            if (po) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL zero_len_extra_word: got %h with nothing outstanding", od);
                end else begin
                    exp = sb.pop_front();
                    void'(cq.pop_front());
                    if (od !== exp) begin
                        fails++;
                        $display("FAIL zero_len_data: got %h required %h", od, exp);
                    end
                end
                npop++;
            end
        end
        tests++;
        if (npop !== 4 || done !== 1) begin
            fails++;
            $display("FAIL zero_len_recover: pops=%0d done=%b, required 4 1", npop, done);
        end
    endtask

    task automatic test_timeout();
        logic pu, po;
        logic [31:0] od, exp;
        int npush = 0;
        int last_pop = -1;
        int err_cyc = -1;
        pulse_start(32'd4);
        wdata = 32'h400;
        for (int i = 0; i < (2 ** TB_BIT) + 100; i++) begin
            step(npush < 2, 1'b1, pu, po, od);
            if (error) begin
                err_cyc = cyc;
                break;
            end
            if (pu) npush++;
            if (po) begin
                last_pop = cyc;
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL timeout_extra_word: got %h with nothing outstanding", od);
                end else begin
                    exp = sb.pop_front();
                    void'(cq.pop_front());
                    if (od !== exp) begin
                        fails++;
                        $display("FAIL timeout_data: got %h required %h", od, exp);
                    end
                end
            end
        end
        // The pop fires on the edge after sample last_pop; the error edge is
        // 2**TB_BIT edges later and is seen at the following sample.
        tests++;
        if (err_cyc - last_pop !== (2 ** TB_BIT) + 1 || etype !== 2'b10 || npush !== 2) begin
            fails++;
            $display("FAIL timeout_delay: error after %0d samples type=%b pushes=%0d, required %0d 10 2",
                     err_cyc - last_pop, etype, npush, (2 ** TB_BIT) + 1);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, pu, po, od);
            tests++;
            if (pu !== 0 || po !== 0 || error !== 1) begin
                fails++;
                $display("FAIL timeout_sticky: push=%b pop=%b error=%b, required 0 0 1", pu, po, error);
            end
        end
        sb.delete();
        cq.delete();
    endtask

    task automatic test_wraparound();
        logic pu, po;
        logic [31:0] od, exp;
        int npush = 0, npop = 0;
        pulse_start(32'd100);
        wdata = 32'h1000;
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pu, po, od);
            if (done) break;
            tests++;
            if (level > 16) begin
                fails++;
                $display("FAIL wrap_level: level=%0d required <= 16", level);
            end
            if (pu) npush++;
            if (po) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL wrap_extra_word: got %h with nothing outstanding", od);
                end else begin
                    exp = sb.pop_front();
                    void'(cq.pop_front());
                    if (od !== exp) begin
                        fails++;
                        $display("FAIL wrap_data: got %h required %h", od, exp);
                    end
                end
                npop++;
            end
        end
        tests++;
        if (npush !== 100 || npop !== 100 || done !== 1 || sb.size() != 0) begin
            fails++;
            $display("FAIL wrap_counts: pushes=%0d pops=%0d done=%b left=%0d, required 100 100 1 0",
                     npush, npop, done, sb.size());
        end
    endtask

    initial begin
        bus.i_wire_data       = 32'd0;
        bus.i_wire_data_valid = 1'b0;
        bus.i_wire_out_ready  = 1'b0;
        test_reset();
        test_basic_stream();
        test_backpressure();
        test_zero_length();
        test_timeout();
        test_wraparound();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
